// File: rtl/sobel_pipe.sv
// Three-stage Sobel edge engine: gradients, magnitudes, then mode-selected output pixel.
// One global advance moves every stage together, so a stalled output freezes the whole pipe.
module sobel_pipe #(
   parameter int PIX_W     = 8,
   parameter int FRAME_PIX = 64,
   parameter int CNT_W     = $clog2(FRAME_PIX)
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic               clear,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [9*PIX_W-1:0] window,
   input  logic [1:0]         mode,
   input  logic [PIX_W-1:0]   threshold,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PIX_W-1:0]   out_pixel,
   output logic [CNT_W-1:0]   pix_count,
   output logic               frame_done
);
   localparam int GW = PIX_W + 3;
   localparam int AW = PIX_W + 2;

   logic                    w_adv, w_last, w_out_hs;
   logic signed [GW-1:0]    w_p [9];
   logic signed [GW-1:0]    w_gx, w_gy;
   logic [AW-1:0]           w_ax, w_ay, w_mx, w_mn;
   logic [GW-1:0]           w_sum, w_l2;
   logic [PIX_W-1:0]        w_res;

   logic                    r_v1, r_v2;
   logic signed [GW-1:0]    r_gx, r_gy;
   logic [AW-1:0]           r_ax, r_ay;
   logic [1:0]              r_mode1, r_mode2;
   logic [PIX_W-1:0]        r_thr1, r_thr2, r_p4_1, r_p4_2;

   assign w_adv    = out_ready | ~out_valid;
   assign in_ready = w_adv & ~clear;
   assign w_out_hs = out_valid & out_ready;
   assign w_last   = (pix_count == CNT_W'(FRAME_PIX - 1));

   always_comb begin
      for (int k = 0; k < 9; k++) w_p[k] = GW'(window[k*PIX_W +: PIX_W]);
   end

   assign w_gx = (w_p[2] + (w_p[5] <<< 1) + w_p[8]) - (w_p[0] + (w_p[3] <<< 1) + w_p[6]);
   assign w_gy = (w_p[6] + (w_p[7] <<< 1) + w_p[8]) - (w_p[0] + (w_p[1] <<< 1) + w_p[2]);

   // |G| of a PIX_W+3 signed value always fits in PIX_W+2 unsigned bits
   assign w_ax = r_gx[GW-1] ? AW'(-r_gx) : AW'(r_gx);
   assign w_ay = r_gy[GW-1] ? AW'(-r_gy) : AW'(r_gy);

   assign w_mx  = (r_ax >= r_ay) ? r_ax : r_ay;
   assign w_mn  = (r_ax >= r_ay) ? r_ay : r_ax;
   assign w_sum = GW'(r_ax) + GW'(r_ay);
   assign w_l2  = GW'(w_mx) + GW'(w_mn >> 1);

   function automatic logic [PIX_W-1:0] sat(input logic [GW-1:0] m);
      return (|m[GW-1:PIX_W]) ? '1 : m[PIX_W-1:0];
   endfunction

   always_comb begin
      w_res = r_p4_2;
      case (r_mode2)
         2'b00:   w_res = sat(w_sum);
         2'b01:   w_res = sat(w_l2);
         2'b10:   w_res = (w_sum >= GW'(r_thr2)) ? '1 : '0;
         default: w_res = r_p4_2;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         r_v1 <= 1'b0;  r_v2 <= 1'b0;
         r_gx <= '0;    r_gy <= '0;
         r_ax <= '0;    r_ay <= '0;
         r_mode1 <= '0; r_mode2 <= '0;
         r_thr1 <= '0;  r_thr2 <= '0;
         r_p4_1 <= '0;  r_p4_2 <= '0;
         out_valid  <= 1'b0;
         out_pixel  <= '0;
         pix_count  <= '0;
         frame_done <= 1'b0;
      end else if (clear) begin
         // in-flight data is dropped by killing valids; payload regs are don't-care
         r_v1       <= 1'b0;
         r_v2       <= 1'b0;
         out_valid  <= 1'b0;
         pix_count  <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= w_out_hs & w_last;
         if (w_out_hs) pix_count <= w_last ? '0 : pix_count + 1'b1;
         if (w_adv) begin
            r_v1      <= in_valid;
            r_gx      <= w_gx;
            r_gy      <= w_gy;
            r_mode1   <= mode;
            r_thr1    <= threshold;
            r_p4_1    <= window[4*PIX_W +: PIX_W];
            r_v2      <= r_v1;
            r_ax      <= w_ax;
            r_ay      <= w_ay;
            r_mode2   <= r_mode1;
            r_thr2    <= r_thr1;
            r_p4_2    <= r_p4_1;
            out_valid <= r_v2;
            out_pixel <= w_res;
         end
      end
   end
endmodule

// File: tb/tb_sobel_pipe.sv
// Bench for sobel_pipe: directed vector table, latency/stall/clear/frame sequences,
// and a random stream scored against an arithmetic reference model.
module tb_sobel_pipe;
   localparam int PW = 8;
   localparam int FP = 4;
   localparam int CW = $clog2(FP);

   logic            clk = 1'b0, n_rst = 1'b0, clear = 1'b0;
   logic            in_valid = 1'b0, out_ready = 1'b1;
   logic            in_ready, out_valid, frame_done;
   logic [9*PW-1:0] window = '0;
   logic [1:0]      mode = '0;
   logic [PW-1:0]   threshold = '0, out_pixel;
   logic [CW-1:0]   pix_count;

   always #5 clk = ~clk;

   sobel_pipe #(.PIX_W(PW), .FRAME_PIX(FP)) dut (
      .clk(clk), .n_rst(n_rst), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .window(window),
      .mode(mode), .threshold(threshold),
      .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
      .pix_count(pix_count), .frame_done(frame_done)
   );

   int errs = 0, checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [9*PW-1:0] w9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
      int v [9];
      logic [9*PW-1:0] w;
      v = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
      w = '0;
      for (int k = 0; k < 9; k++) w[k*PW +: PW] = PW'(v[k]);
      return w;
   endfunction

   // Reference: Sobel gradients and magnitudes in plain integer arithmetic
   function automatic int ref_pix(input logic [9*PW-1:0] w, input logic [1:0] md, input int thr);
      int p [9];
      int gx, gy, ax, ay, mx, mn, m, top;
      top = (1 << PW) - 1;
      for (int k = 0; k < 9; k++) p[k] = int'(w[k*PW +: PW]);
      gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
      gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
      ax = (gx < 0) ? -gx : gx;
      ay = (gy < 0) ? -gy : gy;
      mx = (ax > ay) ? ax : ay;
      mn = (ax > ay) ? ay : ax;
      case (md)
         2'd0:    m = ax + ay;
         2'd1:    m = mx + mn / 2;
         2'd2:    return ((ax + ay) >= thr) ? top : 0;
         default: return p[4];
      endcase
      return (m > top) ? top : m;
   endfunction

   // Scoreboard / protocol monitor, evaluated at negedge for the upcoming posedge
   int exp_q [$];
   int m_cnt = 0, rx = 0, fd_cnt = 0, hold_pix = 0;
   bit m_fd = 1'b0, hold_pend = 1'b0;

   always @(negedge clk) begin
      if (!n_rst) begin
         exp_q.delete();
         m_cnt = 0; m_fd = 1'b0; hold_pend = 1'b0;
      end else begin
         chk("pix_count", pix_count, m_cnt);
         chk("frame_done", frame_done, m_fd);
         chk("in_ready", in_ready, (out_ready || !out_valid) && !clear);
         if (hold_pend) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_pixel", out_pixel, hold_pix);
         end
         if (frame_done) fd_cnt++;
         hold_pend = out_valid && !out_ready && !clear;
         hold_pix  = out_pixel;
         if (clear) begin
            exp_q.delete();
            m_cnt = 0; m_fd = 1'b0;
         end else begin
            m_fd = 1'b0;
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  checks++; errs++;
                  $display("FAIL spurious_output: got pixel %0d expected no output", out_pixel);
               end else chk("sb_pixel", out_pixel, exp_q.pop_front());
               rx++;
               m_fd  = (m_cnt == FP - 1);
               m_cnt = (m_cnt + 1) % FP;
            end
            if (in_valid && in_ready) exp_q.push_back(ref_pix(window, mode, int'(threshold)));
         end
      end
   end

   typedef struct {
      logic [9*PW-1:0] w;
      logic [1:0]      md;
      logic [PW-1:0]   thr;
      logic [PW-1:0]   exp;
   } vec_t;
   vec_t tbl [12];

   // Entered at posedge+#1 with an empty pipe; checks 3-edge latency and single output
   task automatic send_lat(input string nm, input logic [9*PW-1:0] w, input logic [1:0] md,
                           input logic [PW-1:0] thr, input logic [PW-1:0] exp);
      window = w; mode = md; threshold = thr; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      chk({nm, "_lat1"}, out_valid, 0);
      @(posedge clk); #1 chk({nm, "_lat2"}, out_valid, 0);
      @(posedge clk); #1 chk({nm, "_lat3"}, out_valid, 1);
      chk({nm, "_pixel"}, out_pixel, exp);
      @(posedge clk); #1 chk({nm, "_nodup"}, out_valid, 0);
   endtask

   task automatic rand_in();
      window    = {$urandom, $urandom, $urandom};
      mode      = 2'($urandom_range(3));
      threshold = PW'($urandom);
   endtask

   task automatic stream(input string nm, input int n, input int st_lo, input int st_hi,
                         input bit rnd);
      int sent, cyc, rx0;
      bit hs;
      sent = 0; cyc = 0; rx0 = rx;
      rand_in(); in_valid = 1'b1;
      while (sent < n && cyc < n * 20 + 50) begin
         out_ready = rnd ? ($urandom_range(3) != 0) : !(cyc >= st_lo && cyc < st_hi);
         @(negedge clk); hs = in_valid && in_ready;
         @(posedge clk); #1 cyc++;
         if (hs) sent++;
         if (sent >= n) in_valid = 1'b0;
         else if (hs || !in_valid) begin
            rand_in();
            in_valid = rnd ? ($urandom_range(3) != 0) : 1'b1;
         end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
      @(posedge clk); #1;
      chk({nm, "_drained"}, exp_q.size(), 0);
      chk({nm, "_count"}, rx - rx0, n);
   endtask

   task automatic do_clear();
      clear = 1'b1; in_valid = 1'b0;
      @(posedge clk); #1 clear = 1'b0;
   endtask

   initial begin
      logic [9*PW-1:0] wa, wb, wc;
      int fd0;
      wa = w9(1, 2, 3, 4, 5, 6, 7, 8, 9);
      wb = w9(9, 8, 7, 6, 5, 4, 3, 2, 1);
      wc = w9(0, 255, 255, 0, 255, 255, 0, 255, 255);
      tbl[0]  = '{w9(255,255,255,255,255,255,255,255,255), 2'd0, 8'd0, 8'd0};
      tbl[1]  = '{wa, 2'd0, 8'd0,   8'd32};
      tbl[2]  = '{wa, 2'd1, 8'd0,   8'd28};
      tbl[3]  = '{wa, 2'd2, 8'd30,  8'hFF};
      tbl[4]  = '{wa, 2'd2, 8'd33,  8'd0};
      tbl[5]  = '{wa, 2'd2, 8'd32,  8'hFF};
      tbl[6]  = '{wa, 2'd3, 8'd0,   8'd5};
      tbl[7]  = '{wb, 2'd0, 8'd0,   8'd32};
      tbl[8]  = '{wc, 2'd0, 8'd0,   8'd255};
      tbl[9]  = '{wc, 2'd1, 8'd0,   8'd255};
      tbl[10] = '{wc, 2'd2, 8'd255, 8'hFF};
      tbl[11] = '{wc, 2'd3, 8'd0,   8'd255};

      repeat (2) @(posedge clk);
      #1 n_rst = 1'b1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_pixel", out_pixel, 0);
      chk("rst_pix_count", pix_count, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_in_ready", in_ready, 1);

      for (int i = 0; i < 12; i++)
         send_lat($sformatf("vec%0d", i), tbl[i].w, tbl[i].md, tbl[i].thr, tbl[i].exp);

      stream("stall", 5, 2, 6, 1'b0);

      do_clear();
      fd0 = fd_cnt;
      stream("frame", 9, 100, 100, 1'b0);
      chk("frame_pulses", fd_cnt - fd0, 2);
      chk("frame_count_end", pix_count, 1);

      do_clear();
      stream("pre_clear", 2, 100, 100, 1'b0);
      chk("pre_clear_count", pix_count, 2);
      window = wa; mode = 2'd0; in_valid = 1'b1;
      @(posedge clk); #1 window = wb;
      @(posedge clk); #1 in_valid = 1'b0;
      @(posedge clk); #1 chk("clear_inflight", out_valid, 1);
      do_clear();
      chk("clear_out_valid", out_valid, 0);
      chk("clear_pix_count", pix_count, 0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1 chk("clear_no_stale", out_valid, 0);
      end
      send_lat("post_clear", wa, 2'd0, 8'd0, 8'd32);

      stream("random", 200, 0, 0, 1'b1);

      window = wa; mode = 2'd3; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      @(posedge clk); @(posedge clk); #1 out_ready = 1'b0;
      chk("mrst_busy", out_valid, 1);
      n_rst = 1'b0;
      @(posedge clk); #1 n_rst = 1'b1; out_ready = 1'b1;
      chk("mrst_out_valid", out_valid, 0);
      chk("mrst_out_pixel", out_pixel, 0);
      chk("mrst_pix_count", pix_count, 0);
      send_lat("post_rst", wb, 2'd1, 8'd0, 8'd28);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/sobel_pipe.md
Name: sobel_pipe

Overview:
Parametrised, pipelined 3x3 Sobel edge engine; successor to the single-window Sobel block. It accepts one 3x3 window per handshake and returns one edge pixel per handshake, with valid/ready flow control. Pixel width and output mode (L1, approx-L2, binary threshold, bypass) are configurable. It tracks a frame pixel count and pulses frame_done at frame end. It sits between the window/line-buffer stage and the output pixel writer.

Parameters:
PIX_W, 8, pixel width in bits (input and output).
FRAME_PIX, 64, output pixels per frame; must be >= 2.
CNT_W, $clog2(FRAME_PIX), width of the pixel counter.

Ports:
clk  in  1  clock
n_rst  in  1  synchronous active-low reset
clear  in  1  synchronous flush of pipeline and counter
in_valid  in  1  window valid
in_ready  out  1  engine can accept a window this cycle
window  in  9*PIX_W  pixel k at [k*PIX_W +: PIX_W], k=row*3+col, k=0 top-left
mode  in  2  00 L1, 01 approx-L2, 10 threshold, 11 bypass; sampled with window
threshold  in  PIX_W  threshold for mode 10; sampled with window
out_valid  out  1  out_pixel valid
out_ready  in  1  downstream accepts
out_pixel  out  PIX_W  result pixel
pix_count  out  CNT_W  output handshakes completed in the current frame
frame_done  out  1  one-cycle pulse after the last pixel of a frame

Behaviour:
- Reset: n_rst sampled low at posedge. All stage valids=0, out_valid=0, out_pixel=0, pix_count=0, frame_done=0. in_ready=1 in the first cycle after reset.
- Arithmetic, stage 1 (registered):
  - Gx=(p2+2p5+p8)-(p0+2p3+p6)
  - Gy=(p6+2p7+p8)-(p0+2p1+p2)
  - Both signed, PIX_W+3 bits, no overflow possible.
  - mode, threshold and p4 are carried alongside.
- Stage 2 (registered): ax=|Gx|, ay=|Gy|, unsigned PIX_W+2 bits.
- Stage 3 (output register), by mode:
  - 00: m=ax+ay.
  - 01: m=max(ax,ay)+(min(ax,ay)>>1).
  - For 00/01: out_pixel=min(m, 2^PIX_W-1), saturating.
  - 10: out_pixel = all-ones if (ax+ay)>=threshold, else 0.
  - 11: out_pixel=p4.
- Pipeline control:
  - Global advance adv = out_ready | ~out_valid.
  - in_ready = adv (combinational).
  - Input accepted when in_valid & in_ready.
  - When adv=1, every stage shifts by one (valid bits included). When adv=0, all stages hold.
  - Bubbles are not collapsed.
- Latency: an accepted window appears on out_valid at the 3rd posedge after acceptance when out_ready stays 1. Throughput is 1 per cycle.
- Output hold: out_valid and out_pixel stay stable until the handshake completes.
- Counter:
  - On each output handshake (out_valid & out_ready), pix_count increments.
  - On the handshake where pix_count==FRAME_PIX-1, pix_count wraps to 0 and frame_done=1 for the next cycle only.
- clear=1 (synchronous): all stage valids, out_valid, pix_count and frame_done go to 0; in_flight data is discarded; input is not accepted that cycle (in_ready is forced to 0 while clear=1). clear takes priority over a simultaneous handshake.
- Reset mid-frame: identical to clear, and also zeroes out_pixel.
- Simultaneous input and output handshake in the same cycle is legal; no data loss or duplication.

Test Plan:
- Reset, mode 00, window all 8'hFF, out_ready=1 -> out_valid at 3rd posedge after accept, out_pixel=0.
- Window p0..p8 = 1..9 (Gx=8, Gy=24):
  - mode 00 -> 32
  - mode 01 -> 28
  - mode 10 with threshold 30 -> 8'hFF
  - mode 10 with threshold 33 -> 0
  - mode 11 -> 5
- Window 9..1 (Gx=-8, Gy=-24), mode 00 -> 32. Window with p0=p3=p6=0 and others 255 (Gx=1020, Gy=0), modes 00 and 01 -> 255 (saturated).
- Stream 5 back-to-back windows; hold out_ready=0 for 4 cycles mid-stream -> in_ready=0 while out_valid & ~out_ready; out_pixel stable; all 5 results in order with no loss or duplication.
- FRAME_PIX=4, stream 9 windows -> pix_count 0,1,2,3,0,...; frame_done pulses exactly one cycle after the 4th and 8th output handshakes.
- Assert clear with 2 windows in flight and pix_count=2 -> next cycle out_valid=0, pix_count=0, no stale outputs appear; next window has normal 3-cycle latency.
